// File: rtl/lm07_pkg.sv
// Shared types and frame-field positions for the LM07 SPI read path.
package lm07_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } lm07_state_e;

  localparam int FRAME_BITS = 16;
  localparam int INT_MSB    = 15;
  localparam int INT_LSB    = 7;
  localparam int FRAC_MSB   = 6;
  localparam int FRAC_LSB   = 5;

  localparam logic [4:0] LOW_ONES = 5'b11111;

  // The sensor always returns ones below the quarter-degree bits.
  function automatic logic frame_bad(input logic [FRAME_BITS-1:0] raw);
    return raw[FRAC_LSB-1:0] != LOW_ONES;
  endfunction

endpackage

// File: rtl/lm07_sck_gen.sv
// Half-period counter for the sensor serial clock; sck idles low while disabled.
module lm07_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

  logic [HW-1:0] half_cnt_q, half_cnt_d;
  logic          sck_q, sck_d;
  logic          half_end;

  always_comb begin
    half_end   = en && (half_cnt_q == HALF_LAST);
    half_cnt_d = '0;
    sck_d      = 1'b0;
    if (en) begin
      half_cnt_d = half_end ? '0 : half_cnt_q + 1'b1;
      sck_d      = sck_q ^ half_end;
    end
  end

  // rise/fall flag the edge that will drive the new sck level.
  assign rise = half_end && !sck_q;
  assign fall = half_end && sck_q;
  assign sck  = sck_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt_q <= '0;
      sck_q      <= 1'b0;
    end else begin
      half_cnt_q <= half_cnt_d;
      sck_q      <= sck_d;
    end
  end

endmodule

// File: rtl/lm07_read_sequencer.sv
// LM07 read sequencer: on-demand or timed SPI frames, publishes the signed
// integer temperature with a one-cycle strobe.
module lm07_read_sequencer
  import lm07_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int CS_SETUP      = 2,
  parameter int CS_GAP        = 4,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        start,
  input  logic        auto_en,
  input  logic        sio,
  output logic        cs_n,
  output logic        sck,
  output logic        busy,
  output logic        temp_valid,
  output logic [15:0] temp_raw,
  output logic [8:0]  temp_int,
  output logic [1:0]  temp_frac,
  output logic        frame_err
);

  localparam int CMAX = (CS_SETUP > CLK_DIV) ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                             : ((CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP);
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(SAMPLE_PERIOD + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [3:0]    LAST_BIT   = 4'(FRAME_BITS - 1);

  lm07_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  pend_q, pend_d;
  logic                  cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;
  logic                  temp_valid_q, temp_valid_d;
  logic [15:0]           temp_raw_q, temp_raw_d;
  logic [8:0]            temp_int_q, temp_int_d;
  logic [1:0]            temp_frac_q, temp_frac_d;
  logic                  frame_err_q, frame_err_d;
  logic                  accept, hold_exit, timer_wrap;
  logic                  sck_rise, sck_fall;

  lm07_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q == SHIFT),
    .sck  (sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    timer_d    = timer_q;
    pend_d     = pend_q;
    accept     = 1'b0;
    hold_exit  = 1'b0;
    timer_wrap = 1'b0;

    if (!auto_en) begin
      timer_d = '0;
    end else if (ena) begin
      timer_wrap = (timer_q == TIMER_LAST);
      timer_d    = timer_wrap ? '0 : timer_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (ena && (start || pend_q)) begin
          accept  = 1'b1;
          state_d = SETUP;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d   = SHIFT;
          cnt_d     = '0;
          bit_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (sck_rise) shreg_d = {shreg_q[FRAME_BITS-2:0], sio};
        // A bit period ends on its falling edge.
        if (sck_fall) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          hold_exit = 1'b1;
          state_d   = GAP;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A wrap coinciding with an accepted start is absorbed into that frame.
    if (accept)                                       pend_d = 1'b0;
    else if (timer_wrap || (start && state_q != IDLE)) pend_d = 1'b1;

    cs_n_d       = !(state_d == SETUP || state_d == SHIFT || state_d == HOLD);
    busy_d       = (state_d != IDLE);
    temp_valid_d = hold_exit;
    temp_raw_d   = hold_exit ? shreg_q : temp_raw_q;
    temp_int_d   = hold_exit ? shreg_q[INT_MSB:INT_LSB] : temp_int_q;
    temp_frac_d  = hold_exit ? shreg_q[FRAC_MSB:FRAC_LSB] : temp_frac_q;
    frame_err_d  = hold_exit ? frame_bad(shreg_q) : frame_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      timer_q      <= '0;
      pend_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      temp_valid_q <= 1'b0;
      temp_raw_q   <= '0;
      temp_int_q   <= '0;
      temp_frac_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      timer_q      <= timer_d;
      pend_q       <= pend_d;
      cs_n_q       <= cs_n_d;
      busy_q       <= busy_d;
      temp_valid_q <= temp_valid_d;
      temp_raw_q   <= temp_raw_d;
      temp_int_q   <= temp_int_d;
      temp_frac_q  <= temp_frac_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign cs_n       = cs_n_q;
  assign busy       = busy_q;
  assign temp_valid = temp_valid_q;
  assign temp_raw   = temp_raw_q;
  assign temp_int   = temp_int_q;
  assign temp_frac  = temp_frac_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_lm07_read_sequencer.sv
// Directed bench for lm07_read_sequencer with an LM07 sensor model and a
// scoreboard of expected frames. Cycle n of a frame is the period after edge acc+n-1.
module tb_lm07_read_sequencer;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_GAP   = 4;
  localparam int PERIOD   = 1000;
  localparam int TV_CYCLE = 1 + CS_SETUP + 33 * CLK_DIV;

  logic        clk, rst_n, ena, start, auto_en, sio;
  logic        cs_n, sck, busy, temp_valid, frame_err;
  logic [15:0] temp_raw;
  logic [8:0]  temp_int;
  logic [1:0]  temp_frac;

  // {raw[15:0], int[8:0], frac[1:0], err}
  logic [27:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tv_count = 0;
  int last_tv_cyc = 0;
  int first_rise_cyc = 0;
  int busy_rise_cyc = 0;
  int rise_cnt = 0;
  int bit_idx = -1;
  logic [15:0] temp_set = 16'h0000;
  logic prev_cs_n = 1'b1, prev_sck = 1'b0, prev_busy = 1'b0;

  lm07_read_sequencer #(
    .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP), .SAMPLE_PERIOD(PERIOD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .auto_en(auto_en), .sio(sio),
    .cs_n(cs_n), .sck(sck), .busy(busy), .temp_valid(temp_valid), .temp_raw(temp_raw),
    .temp_int(temp_int), .temp_frac(temp_frac), .frame_err(frame_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // sensor model: MSB valid once cs_n falls, next bit after each sck fall
  always @(negedge cs_n) bit_idx = 15;
  always @(negedge sck) if (!cs_n) bit_idx = bit_idx - 1;
  assign sio = (bit_idx >= 0 && bit_idx < 16) ? temp_set[bit_idx[3:0]] : 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // monitor + scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cs_n = 1'b1;
      prev_sck  = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (!cs_n && prev_cs_n) rise_cnt = 0;
      if (sck && !prev_sck && !cs_n) begin
        rise_cnt++;
        if (rise_cnt == 1) first_rise_cyc = cyc;
      end
      if (busy && !prev_busy) busy_rise_cyc = cyc;
      if (temp_valid) begin
        logic [27:0] e;
        tv_count++;
        last_tv_cyc = cyc;
        chk("sck_rises_per_frame", 32'(rise_cnt), 32'd16);
        chk("valid_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("temp_raw", 32'(temp_raw), 32'(e[27:12]));
          chk("temp_int", 32'(temp_int), 32'(e[11:3]));
          chk("temp_frac", 32'(temp_frac), 32'(e[2:1]));
          chk("frame_err", 32'(frame_err), 32'(e[0]));
        end
      end
      prev_cs_n = cs_n;
      prev_sck  = sck;
      prev_busy = busy;
    end
  end

  // driver tasks
  task automatic push_exp(input logic [15:0] raw, input logic [8:0] ti,
                          input logic [1:0] tf, input logic err);
    exp_q.push_back({raw, ti, tf, err});
  endtask

  task automatic wait_tv(input string tag, input int n_before, input int limit);
    int i = 0;
    while (tv_count <= n_before && i < limit) begin
      @(negedge clk); #1;
      i++;
    end
    chk({"strobe_within_budget_", tag}, 32'(tv_count > n_before), 32'd1);
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy && i < 400) begin
      @(negedge clk); #1;
      i++;
    end
  endtask

  task automatic pulse_start(output int acc);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    acc = cyc;
  endtask

  task automatic run_frame(input string tag, input logic [15:0] raw, input logic [8:0] ti,
                           input logic [1:0] tf, input logic err);
    int acc, n0;
    wait_idle();
    temp_set = raw;
    push_exp(raw, ti, tf, err);
    n0 = tv_count;
    pulse_start(acc);
    #1;
    chk({tag, "_busy_cycle1"}, 32'(busy), 32'd1);
    chk({tag, "_cs_n_cycle1"}, 32'(cs_n), 32'd0);
    wait_tv(tag, n0, 400);
    chk({tag, "_valid_cycle"}, 32'(last_tv_cyc - acc + 1), 32'(TV_CYCLE));
    chk({tag, "_first_rise_cycle"}, 32'(first_rise_cyc - acc + 1), 32'(1 + CS_SETUP + CLK_DIV));
    chk({tag, "_cs_n_high_at_valid"}, 32'(cs_n), 32'd1);
    @(negedge clk); #1;
    chk({tag, "_valid_one_cycle"}, 32'(temp_valid), 32'd0);
    chk({tag, "_int_held"}, 32'(temp_int), 32'(ti));
  endtask

  initial begin
    int a, b, e, acc, n0, t1, t2, t3;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; auto_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_cs_n", 32'(cs_n), 32'd1);
    chk("reset_sck", 32'(sck), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(temp_valid), 32'd0);
    chk("reset_raw", 32'(temp_raw), 32'd0);
    chk("reset_int_frac_err", 32'({temp_int, temp_frac, frame_err}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // single on-demand frames
    run_frame("pos", 16'h0D1F, 9'd26, 2'd0, 1'b0);
    run_frame("neg", 16'hF39F, 9'h1E7, 2'd0, 1'b0);
    run_frame("bad_low", 16'h0D00, 9'd26, 2'd0, 1'b1);

    // start while busy plus a timer wrap inside the same frame: one extra frame
    wait_idle();
    temp_set = 16'h0D7F;
    push_exp(16'h0D7F, 9'd26, 2'd3, 1'b0);
    push_exp(16'h0D7F, 9'd26, 2'd3, 1'b0);
    n0 = tv_count;
    @(negedge clk); auto_en = 1'b1; a = cyc;
    repeat (948) @(negedge clk);
    pulse_start(acc);
    repeat (10) @(negedge clk);
    pulse_start(b);
    while (cyc < a + 1005) @(negedge clk);
    auto_en = 1'b0;
    wait_tv("pend_first", n0, 300);
    t1 = last_tv_cyc;
    chk("pend_first_valid_cycle", 32'(t1 - acc + 1), 32'(TV_CYCLE));
    wait_tv("pend_second", n0 + 1, 300);
    // strobe occupies cycle t1+1; acceptance edge comes CS_GAP cycles later
    chk("pend_accept_edge", 32'(busy_rise_cyc - (t1 + 1)), 32'(CS_GAP));
    repeat (300) @(negedge clk);
    chk("pend_exactly_one_extra", 32'(tv_count - n0), 32'd2);

    // periodic sampling
    wait_idle();
    temp_set = 16'h241F;
    repeat (3) push_exp(16'h241F, 9'd72, 2'd0, 1'b0);
    n0 = tv_count;
    @(negedge clk); auto_en = 1'b1; a = cyc;
    wait_tv("auto1", n0, 1300);
    t1 = last_tv_cyc;
    chk("auto_first_valid", 32'(t1 - a), 32'(PERIOD + 1 + TV_CYCLE - 1));
    wait_tv("auto2", n0 + 1, 1100);
    t2 = last_tv_cyc;
    chk("auto_spacing_1", 32'(t2 - t1), 32'(PERIOD));
    wait_tv("auto3", n0 + 2, 1100);
    t3 = last_tv_cyc;
    chk("auto_spacing_2", 32'(t3 - t2), 32'(PERIOD));
    @(negedge clk); auto_en = 1'b0;
    repeat (300) @(negedge clk);
    chk("auto_off_no_frame", 32'(tv_count - n0), 32'd3);

    // asynchronous reset during SHIFT bit 8
    wait_idle();
    temp_set = 16'h0D1F;
    n0 = tv_count;
    pulse_start(acc);
    repeat (69) @(negedge clk);
    #1;
    chk("pre_reset_cs_n_low", 32'(cs_n), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_cs_n", 32'(cs_n), 32'd1);
    chk("async_reset_sck", 32'(sck), 32'd0);
    chk("async_reset_raw", 32'(temp_raw), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("no_valid_after_abort", 32'(tv_count - n0), 32'd0);
    run_frame("post_reset", 16'h0D1F, 9'd26, 2'd0, 1'b0);

    // ena dropped mid-frame with auto_en and a pending start
    wait_idle();
    temp_set = 16'h0D1F;
    repeat (3) push_exp(16'h0D1F, 9'd26, 2'd0, 1'b0);
    n0 = tv_count;
    @(negedge clk); start = 1'b1; auto_en = 1'b1;
    @(negedge clk); start = 1'b0; acc = cyc; a = acc - 1;
    repeat (19) @(negedge clk);
    pulse_start(b);
    repeat (29) @(negedge clk);
    @(negedge clk); ena = 1'b0; b = cyc;
    wait_tv("ena_low_frame", n0, 300);
    chk("ena_low_frame_cycle", 32'(last_tv_cyc - acc + 1), 32'(TV_CYCLE));
    repeat (300) @(negedge clk);
    #1;
    chk("ena_low_no_new_frame", 32'(tv_count - n0), 32'd1);
    chk("ena_low_idle", 32'(busy), 32'd0);
    @(negedge clk); ena = 1'b1; e = cyc;
    repeat (2) @(negedge clk);
    chk("ena_pending_accept", 32'(busy_rise_cyc - e), 32'd1);
    wait_tv("ena_pending_frame", n0 + 1, 300);
    wait_tv("ena_timer_frame", n0 + 2, 1200);
    // timer resumed from its held value b-a, so it wraps PERIOD-(b-a) edges after e
    chk("timer_held_while_ena_low", 32'(last_tv_cyc), 32'(e + PERIOD - (b - a) + 1 + TV_CYCLE - 1));
    @(negedge clk); auto_en = 1'b0;
    repeat (20) @(negedge clk);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
